// File: rtl/s27_bist_ctrl_if.sv
// s27_bist_ctrl_if: run handshake, s27 stimulus/response and signature bundle
interface s27_bist_ctrl_if;
  logic        start_i;
  logic        g17_i;
  logic        g0_o;
  logic        g1_o;
  logic        g2_o;
  logic        g3_o;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [15:0] sig_o;
  modport master (
    input  start_i, g17_i,
    output g0_o, g1_o, g2_o, g3_o, busy_o, done_o, pass_o, sig_o
  );
  modport slave (
    output start_i, g17_i,
    input  g0_o, g1_o, g2_o, g3_o, busy_o, done_o, pass_o, sig_o
  );
endinterface

// File: rtl/s27_bist_ctrl.sv
// s27_bist_ctrl: LFSR pattern generator and CRC-16 response compactor for an s27 BIST run
module s27_bist_ctrl #(
  parameter int          NPAT     = 64,
  parameter int          INIT_CYC = 4,
  parameter logic [3:0]  INIT_VEC = 4'b0000,
  parameter logic [3:0]  SEED     = 4'b1001,
  parameter logic [15:0] GOLDEN   = 16'h0000
) (
  input logic             ck_i,
  input logic             rst_i,
  s27_bist_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
  // an all-zero seed would lock the LFSR, so it is swapped for 0001
  localparam logic [3:0] SEED_EFF = (SEED == 4'b0000) ? 4'b0001 : SEED;
  state_t      state_q, state_d;
  logic [3:0]  lfsr_q, lfsr_d;
  logic [3:0]  g_q, g_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [9:0]  scnt_q, scnt_d;
  logic [15:0] sig_q, sig_d;
  logic        fb;
  // next state, pattern/signature stepping; stimulus is registered from the next state so the pattern and its response share a cycle
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    fcnt_d  = fcnt_q;
    scnt_d  = scnt_q;
    fb      = sig_q[15] ^ bus.g17_i;
    unique case (state_q)
      IDLE, DONE: if (bus.start_i) begin
        state_d = (INIT_CYC == 0) ? RUN : INIT;
        lfsr_d  = SEED_EFF;
        sig_d   = 16'hFFFF;
        fcnt_d  = '0;
        scnt_d  = '0;
      end
      INIT: begin
        fcnt_d = fcnt_q + 4'd1;
        if (fcnt_q == 4'(INIT_CYC - 1)) state_d = RUN;
      end
      RUN: begin
        sig_d  = {sig_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        scnt_d = scnt_q + 10'd1;
        if (scnt_q == 10'(NPAT - 1)) state_d = DONE;
      end
      default: ;
    endcase
    g_d = (state_d == RUN) ? lfsr_d : (state_d == INIT) ? INIT_VEC : 4'b0000;
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      sig_q   <= 16'hFFFF;
      fcnt_q  <= '0;
      scnt_q  <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
      g_q     <= g_d;
    end
  end
  assign {bus.g3_o, bus.g2_o, bus.g1_o, bus.g0_o} = g_q;
  assign bus.busy_o = (state_q == INIT) || (state_q == RUN);
  assign bus.done_o = state_q == DONE;
  assign bus.pass_o = (state_q == DONE) && (sig_q == GOLDEN);
  assign bus.sig_o  = sig_q;
endmodule

// File: tb/tb_s27_bist_ctrl.sv
// tb_s27_bist_ctrl: randomized bench for s27_bist_ctrl against a cycle-level reference model, with an s27 circuit as DUT
module tb_s27_bist_ctrl;
  localparam int          NPAT = 64;
  localparam int          ICYC = 4;
  localparam logic [3:0]  SEED = 4'b1001;
  localparam logic [3:0]  IVEC = 4'b0000;
  localparam logic [15:0] GOLD = 16'h0000;
  logic ck = 1'b0;
  logic rst = 1'b1;
  logic use_s27 = 1'b0, flip = 1'b0, rbit = 1'b0, rnd_en = 1'b1, rc = 1'b0;
  int n_chk = 0, n_pass = 0;
  int ph, t, k;
  logic [15:0] msig;
  logic [2:0]  mst;
  logic [3:0]  pat [15];
  logic [2:0]  hst;
  logic [3:0]  hs;
  always #5 ck = ~ck;
  s27_bist_ctrl_if ifa ();
  s27_bist_ctrl_if ifb ();
  s27_bist_ctrl dut_a (.ck_i(ck), .rst_i(rst), .bus(ifa.master));
  s27_bist_ctrl #(.NPAT(1), .INIT_CYC(0), .SEED(4'b0000), .GOLDEN(16'hEFDF))
    dut_b (.ck_i(ck), .rst_i(rst), .bus(ifb.master));
  // ISCAS s27: returns {G17, G10, G11, G13}; st = {G5, G6, G7}
  function automatic logic [3:0] s27(input logic [3:0] g, input logic [2:0] st);
    logic g14, g8, g12, g15, g16, g9, g11, g10, g13;
    g14 = ~g[0];
    g8  = g14 & st[1];
    g12 = ~(g[1] | st[0]);
    g15 = g12 | g8;
    g16 = g[3] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(st[2] | g9);
    g10 = ~(g14 | g11);
    g13 = ~(g[2] | g12);
    return {~g11, g10, g11, g13};
  endfunction
  assign hs = s27({ifa.g3_o, ifa.g2_o, ifa.g1_o, ifa.g0_o}, hst);
  always_ff @(posedge ck) hst <= rst ? 3'b000 : hs[2:0];
  assign ifa.g17_i = use_s27 ? hs[3] ^ flip : rbit;
  function automatic logic [15:0] crc(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
  function automatic logic [3:0] gexp();
    return (ph == 2) ? pat[k % 15] : (ph == 1) ? IVEC : 4'b0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask
  // advance the reference model across the coming rising edge
  task automatic model_step();
    logic [3:0] ge, s;
    logic b;
    ge = gexp();
    s  = s27(ge, mst);
    b  = use_s27 ? s[3] ^ flip : rbit;
    if (rst) begin
      ph = 0;
      msig = 16'hFFFF;
      mst = 3'b000;
    end else begin
      mst = s[2:0];
      if (ph == 0 || ph == 3) begin
        if (ifa.start_i) begin
          ph = (ICYC == 0) ? 2 : 1;
          t = 0;
          k = 0;
          msig = 16'hFFFF;
        end
      end else if (ph == 1) begin
        t++;
        if (t == ICYC) ph = 2;
      end else begin
        msig = crc(msig, b);
        k++;
        if (k == NPAT) ph = 3;
      end
    end
  endtask
  task automatic check_a();
    logic [2:0] ef;
    ef = {ph == 1 || ph == 2, ph == 3, ph == 3 && msig == GOLD};
    chk("a_g", 32'({ifa.g3_o, ifa.g2_o, ifa.g1_o, ifa.g0_o}), 32'(gexp()));
    chk("a_flags", 32'({ifa.busy_o, ifa.done_o, ifa.pass_o}), 32'(ef));
    chk("a_sig", 32'(ifa.sig_o), 32'(msig));
  endtask
  task automatic cyc(input logic s, input logic r);
    ifa.start_i = s;
    rst = r;
    rbit = rnd_en ? 1'($urandom) : rc;
    model_step();
    @(negedge ck);
    check_a();
  endtask
  task automatic chk_b(input string tag, input logic [3:0] g, input logic [2:0] f, input logic [15:0] s);
    chk(tag, 32'({ifb.g3_o, ifb.g2_o, ifb.g1_o, ifb.g0_o, ifb.busy_o, ifb.done_o, ifb.pass_o}), 32'({g, f}));
    chk({tag, "_sig"}, 32'(ifb.sig_o), 32'(s));
  endtask
  initial begin
    int busy_n;
    logic [15:0] es, sig1m;
    logic [15:0] q[$];
    pat[0] = SEED;
    for (int i = 1; i < 15; i++) pat[i] = {pat[i-1][2:0], pat[i-1][3] ^ pat[i-1][2]};
    ifa.start_i = 1'b0;
    ifb.start_i = 1'b0;
    ifb.g17_i = 1'b0;
    ph = 0; t = 0; k = 0; msig = 16'hFFFF; mst = 3'b000;
    repeat (3) cyc(1'b0, 1'b1);
    chk_b("b_rst", 4'b0000, 3'b000, 16'hFFFF);
    busy_n = 0;
    cyc(1'b1, 1'b0);
    if (ifa.busy_o) busy_n++;
    for (int i = 0; i < 80; i++) begin
      cyc((ph == 1 || ph == 2) ? 1'($urandom_range(0, 3) == 0) : 1'b0, 1'b0);
      if (ifa.busy_o) busy_n++;
    end
    chk("busy_len", 32'(busy_n), 32'(ICYC + NPAT));
    rnd_en = 1'b0;
    rc = 1'($urandom);
    for (int i = 0; i < 150; i++) begin
      cyc(1'b1, 1'b0);
      if (ph == 3) q.push_back(ifa.sig_o);
    end
    es = 16'hFFFF;
    repeat (NPAT) es = crc(es, rc);
    chk("b2b_runs", 32'(q.size()), 32'd2);
    if (q.size() >= 2) begin
      chk("b2b_sig0", 32'(q[0]), 32'(es));
      chk("b2b_sig1", 32'(q[1]), 32'(es));
    end
    for (int i = 0; i < 80; i++) cyc(1'b0, 1'b0);
    rnd_en = 1'b1;
    use_s27 = 1'b1;
    repeat (2) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 75; i++) cyc(1'b0, 1'b0);
    sig1m = msig;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("rst_mid", 32'({ifa.busy_o, ifa.done_o, ifa.pass_o, ifa.g3_o, ifa.g2_o, ifa.g1_o, ifa.g0_o, ifa.sig_o}), 32'({7'b0, 16'hFFFF}));
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 75; i++) cyc(1'b0, 1'b0);
    chk("rerun_sig", 32'(ifa.sig_o), 32'(sig1m));
    repeat (2) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 75; i++) begin
      flip = (i == 20);
      cyc(1'b0, 1'b0);
    end
    flip = 1'b0;
    chk("flip_diff", 32'(ifa.sig_o != sig1m), 32'd1);
    use_s27 = 1'b0;
    cyc(1'b0, 1'b1);
    ifb.start_i = 1'b1;
    ifb.g17_i = 1'b0;
    cyc(1'b0, 1'b0);
    ifb.start_i = 1'b0;
    chk_b("b_run0", 4'b0001, 3'b100, 16'hFFFF);
    cyc(1'b0, 1'b0);
    chk_b("b_done0", 4'b0000, 3'b011, 16'hEFDF);
    ifb.start_i = 1'b1;
    ifb.g17_i = 1'b1;
    cyc(1'b0, 1'b0);
    ifb.start_i = 1'b0;
    chk_b("b_run1", 4'b0001, 3'b100, 16'hFFFF);
    cyc(1'b0, 1'b0);
    chk_b("b_done1", 4'b0000, 3'b010, 16'hFFFE);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
